// File: rtl/serial_frame_receiver.sv
// Serial link receiver: syncs a 3-wire Arduino link to CLOCK_50, assembles one
// frame of fixed-point pixels and hands it over as a double-buffered flat vector.
module serial_frame_receiver #(
    parameter int numInputs     = 784,
    parameter int pixelBits     = 8,
    parameter int dataWidth     = 16,
    parameter int dataFracWidth = 8,
    parameter int errWidth      = 8
) (
    input  logic                           CLOCK_50,
    input  logic                           reset,
    input  logic                           serialClock,
    input  logic                           serialData,
    input  logic                           serialFrame,
    input  logic                           consume,
    output logic [numInputs*dataWidth-1:0] NNin,
    output logic                           outValid,
    output logic                           overrun,
    output logic                           frameErr,
    output logic [errWidth-1:0]            errCount,
    output logic                           busy
);
    localparam int SHIFT = dataFracWidth - pixelBits;
    localparam int BW    = $clog2(pixelBits);
    localparam int IW    = (numInputs > 1) ? $clog2(numInputs) : 1;

    typedef enum logic [1:0] {IDLE, RECV, COMMIT, WAIT_END} state_t;

    state_t                                state_q;
    logic [2:0]                            sclk_q, sfrm_q;
    logic [1:0]                            sdat_q;
    logic [pixelBits-2:0]                  shift_q;
    logic [BW-1:0]                         bit_q;
    logic [IW-1:0]                         pix_q;
    logic [numInputs-1:0][dataWidth-1:0]   asm_q, nnin_q;
    logic                                  valid_q, overrun_q, ferr_q, busy_q;
    logic [errWidth-1:0]                   errcnt_q;

    logic                 sclkRise, frameRise, frameLvl, sdata;
    logic [pixelBits-1:0] pix_d;
    logic [dataWidth-1:0] word_d;

    // Bit [1] of each chain is the synchronised level, bit [2] the edge history.
    assign sclkRise  = sclk_q[1] & ~sclk_q[2];
    assign frameRise = sfrm_q[1] & ~sfrm_q[2];
    assign frameLvl  = sfrm_q[1];
    assign sdata     = sdat_q[1];
    assign pix_d     = {shift_q, sdata};
    assign word_d    = dataWidth'(pix_d) << SHIFT;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= IDLE;
            sclk_q    <= '0;
            sfrm_q    <= '0;
            sdat_q    <= '0;
            shift_q   <= '0;
            bit_q     <= '0;
            pix_q     <= '0;
            asm_q     <= '0;
            nnin_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
            errcnt_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[1:0], serialClock};
            sfrm_q <= {sfrm_q[1:0], serialFrame};
            sdat_q <= {sdat_q[0], serialData};
            ferr_q <= 1'b0;
            if (consume)
                valid_q <= 1'b0;

            case (state_q)
                IDLE: if (frameRise) begin
                    bit_q   <= '0;
                    pix_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= RECV;
                end
                RECV: begin
                    // A dropped frame line beats a simultaneous final bit.
                    if (!frameLvl) begin
                        ferr_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                        if (errcnt_q != '1)
                            errcnt_q <= errcnt_q + 1'b1;
                    end else if (sclkRise) begin
                        shift_q <= pix_d[pixelBits-2:0];
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == BW'(pixelBits-1)) begin
                            asm_q[pix_q] <= word_d;
                            bit_q        <= '0;
                            pix_q        <= pix_q + 1'b1;
                            if (pix_q == IW'(numInputs-1))
                                state_q <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    // Commit overrides a coincident consume.
                    nnin_q  <= asm_q;
                    valid_q <= 1'b1;
                    if (valid_q && !consume)
                        overrun_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= WAIT_END;
                end
                WAIT_END: if (!frameLvl)
                    state_q <= IDLE;
            endcase
        end
    end

    assign NNin     = nnin_q;
    assign outValid = valid_q;
    assign overrun  = overrun_q;
    assign frameErr = ferr_q;
    assign errCount = errcnt_q;
    assign busy     = busy_q;
endmodule

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
- Upstream feeder for the NeuralNetwork block. Receives one image frame from the Arduino over a 3-wire serial link (clock, data, frame-enable).
- Synchronises the link to CLOCK_50 and converts each unsigned pixel to dataWidth fixed-point.
- Presents the whole frame as a flat, double-buffered NNin vector.
- Uses a valid/consume handshake so the control FSM only starts inference on a complete, stable image.

Parameters:
- numInputs, 784, pixels per frame.
- pixelBits, 8, bits per received pixel (unsigned).
- dataWidth, 16, output word width (signed fixed-point).
- dataFracWidth, 8, output fractional bits. Legal values: pixelBits <= dataFracWidth <= dataWidth-1.
- errWidth, 8, width of the saturating error counter.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high.
- serialClock  in  1  async link clock; data is sampled on its rising edge.
- serialData  in  1  async link data, MSB of each pixel first.
- serialFrame  in  1  async; high for the duration of a frame.
- consume  in  1  one-cycle pulse; the consumer has taken NNin.
- NNin  out  numInputs*dataWidth  committed frame; pixel i occupies bits [i*dataWidth +: dataWidth].
- outValid  out  1  a committed frame is available and not yet consumed.
- overrun  out  1  sticky; a frame was committed while outValid was already 1.
- frameErr  out  1  one-cycle pulse; the frame was aborted (short frame).
- errCount  out  errWidth  saturating count of aborted frames.
- busy  out  1  high in RECV or COMMIT.

Behaviour:
- Reset values: NNin=0, outValid=0, overrun=0, frameErr=0, errCount=0, busy=0, state=IDLE. Synchroniser flops and the assembly buffer are also cleared.
- Synchronisation: serialClock, serialData and serialFrame each pass through 2 flops.
- Edge detection: a third flop on the synchronised clock and frame lines gives the rising edges sclkRise and frameRise. Data is taken from the synchronised serialData in the same cycle as sclkRise.
- Link-to-internal latency: 3 CLOCK_50 cycles. Link clock high and low phases must each be ≥4 CLOCK_50 cycles. Faster links are out of spec and not detected.
- FSM states:
  - IDLE: busy=0. On frameRise, clear bitCnt and pixCnt and go to RECV.
  - RECV: on each sclkRise, shiftReg <= {shiftReg[pixelBits-2:0], sdata} and bitCnt++.
    - When bitCnt reaches pixelBits-1 on a sclkRise, the completed pixel is written to assembly slot pixCnt; bitCnt <= 0; pixCnt++.
    - Once pixCnt reaches numInputs, go to COMMIT.
    - If the synchronised frame line goes low before that: go to IDLE, pulse frameErr for 1 cycle, errCount++ (saturating at all-ones). The assembly buffer is discarded and NNin is left unchanged.
  - COMMIT (1 cycle): NNin <= assembly buffer; outValid <= 1. If outValid was already 1 and consume is not asserted this cycle, set overrun. Go to WAIT_END.
  - WAIT_END: ignore further sclkRise. When the frame line is low, go to IDLE. A new frame therefore requires serialFrame to drop and rise again.
- Pixel conversion: word = zero-extended pixel << (dataFracWidth - pixelBits). With defaults, word = {8'h00, pixel}, representing pixel/256, range 0..0.996. The sign bit is always 0.
- Handshake:
  - consume clears outValid on the next edge.
  - If consume and COMMIT coincide, the COMMIT wins: outValid=1 and no overrun.
  - consume while outValid=0 is ignored.
  - NNin only changes in COMMIT, so it is stable while outValid=1 unless a new frame overruns it.
- overrun clears only on reset.
- Reset mid-frame: everything returns to reset values. The partial frame is lost and no frameErr is raised.
- sclkRise outside RECV has no effect. frameRise outside IDLE is ignored.

Test Plan:
- Reset, then send numInputs=784 pixels with pixel i = i mod 256 -> outValid rises 1 cycle after the last pixel's sclkRise is detected; NNin word 0 = 16'h0000, word 1 = 16'h0001, word 255 = 16'h00FF, word 256 = 16'h0000; busy drops; frameErr stays 0.
- With numInputs=4, send pixels 0xA5, 0x3C and then drop serialFrame -> frameErr pulses once, errCount=1, NNin still holds the previous frame, state returns to IDLE. Repeat 300 aborts with errWidth=8 -> errCount=255 (saturated).
- With numInputs=4, commit frame A ({0x11,0x22,0x33,0x44}), no consume, then send frame B -> NNin = B words {0x0011…}, overrun=1, outValid=1.
- Assert consume in the same cycle as COMMIT -> outValid=1, overrun=0. Pulse consume one cycle later -> outValid=0 on the next edge.
- Send a full frame plus 8 extra sclk edges before serialFrame falls -> NNin unaffected by the extra bits. A second frame is then received correctly.
- Assert reset after 2 of 4 pixels -> all outputs 0, frameErr stays 0. A following complete frame commits correctly.
